// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types, constants and helpers for the hazard-detection
//                and forwarding controller.
//                - shadow_ent_t : one in-flight writer {v, rd, a}
//                - SEL_NONE     : select value meaning "no forward"
//                - selw()       : width of one forwarding select field
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Storage widths of the shadow-entry fields. The register-number field is
    // sized for the widest supported register file (AW <= AW_MAX), the stage
    // field for the deepest supported pipeline (DEPTH < 2**SELW_MAX). Narrower
    // instances zero-extend into these fields.
    localparam int unsigned AW_MAX   = 8;
    localparam int unsigned SELW_MAX = 4;

    // Select value meaning "no forward": use register-file / ID_EX data.
    localparam int unsigned SEL_NONE = 0;

    // One in-flight register writer.
    //   v  : entry holds a real register write
    //   rd : destination register
    //   a  : stage whose output first carries the result
    typedef struct packed {
        logic                v;
        logic [AW_MAX-1:0]   rd;
        logic [SELW_MAX-1:0] a;
    } shadow_ent_t;

    // Select field width for a pipeline with 'depth' post-ID stages:
    // values 0 (no forward) .. depth must be representable.
    function automatic int unsigned selw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit_match.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_match
//  Description : Combinational nearest-match priority encoder. For one source
//                register it finds the youngest (smallest stage index) valid
//                shadow entry in stages LO..DEPTH that writes that register.
//                Register 0 and unused sources never match.
//  Ports       : ent_i   - shadow entries, index = stage (1 = EX)
//                src_i   - source register number (zero-extended)
//                used_i  - source is actually read
//                hit_o   - a matching writer exists
//                s_o     - stage of the nearest match
//                a_o     - result-available stage of the nearest match
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned LO    = 1,
    parameter int unsigned SELW  = 2
) (
    input  shadow_ent_t         ent_i [1:DEPTH],
    input  logic [AW_MAX-1:0]   src_i,
    input  logic                used_i,
    output logic                hit_o,
    output logic [SELW-1:0]     s_o,
    output logic [SELW_MAX-1:0] a_o
);

    // Scan from the oldest stage towards EX so the last hit written is the
    // nearest one; farther writers are shadowed by it.
    always_comb begin
        hit_o = 1'b0;
        s_o   = '0;
        a_o   = '0;
        for (int s = int'(DEPTH); s >= 1; s--) begin
            if ((s >= int'(LO)) && used_i && (src_i != '0) &&
                ent_i[s].v && (ent_i[s].rd == src_i)) begin
                hit_o = 1'b1;
                s_o   = SELW'(s);
                a_o   = ent_i[s].a;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Hazard-detection and forwarding controller. Tracks in-flight
//                register writers in a shadow pipeline and derives the
//                load-use / branch-operand stall, the EX-stage forwarding
//                selects and the ID-stage (branch comparator) selects.
//  Ports       : clk_i, rst_i       - clock, synchronous active-high reset
//                id_*               - instruction currently in ID
//                hold_i             - global freeze of all state
//                stall_o            - hold PC/IF_ID, bubble into EX
//                fwd_id_sel_o       - per-source ID operand mux select
//                fwd_ex_sel_o       - per-source EX operand mux select
//                pipe_empty_o       - no valid writer in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned AW         = 5,
    parameter int unsigned NSRC       = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 id_valid_i,
    input  logic [NSRC*AW-1:0]                   id_rs_i,
    input  logic [NSRC-1:0]                      id_rs_used_i,
    input  logic [AW-1:0]                        id_rd_i,
    input  logic                                 id_reg_write_i,
    input  logic                                 id_is_load_i,
    input  logic                                 id_is_branch_i,
    input  logic                                 hold_i,
    output logic                                 stall_o,
    output logic [NSRC*$clog2(DEPTH+1)-1:0]      fwd_id_sel_o,
    output logic [NSRC*$clog2(DEPTH+1)-1:0]      fwd_ex_sel_o,
    output logic                                 pipe_empty_o
);

    localparam int unsigned SELW = selw(DEPTH);

    localparam logic [SELW_MAX-1:0] c_alu_a  = SELW_MAX'(1);
    localparam logic [SELW_MAX-1:0] c_load_a = SELW_MAX'(LOAD_STAGE);
    localparam logic [SELW_MAX-1:0] c_last   = SELW_MAX'(DEPTH);

    // Shadow pipeline (index = stage, 1 = EX) and the EX instruction sources.
    shadow_ent_t        r_ent_q [1:DEPTH];
    shadow_ent_t        w_ent_d [1:DEPTH];
    logic [NSRC*AW-1:0] r_ex_rs_q,   w_ex_rs_d;
    logic [NSRC-1:0]    r_ex_used_q, w_ex_used_d;

    // Nearest-match results per source.
    logic                w_id_hit [NSRC];
    logic [SELW-1:0]     w_id_s   [NSRC];
    logic [SELW_MAX-1:0] w_id_a   [NSRC];
    logic                w_ex_hit [NSRC];
    logic [SELW-1:0]     w_ex_s   [NSRC];
    logic [SELW_MAX-1:0] w_ex_a   [NSRC];

    // ID sources look at every stage; EX sources skip stage 1, which is the
    // EX instruction itself.
    for (genvar k = 0; k < int'(NSRC); k++) begin : g_src
        hazard_match #(
            .DEPTH (DEPTH),
            .LO    (1),
            .SELW  (SELW)
        ) u_id_match (
            .ent_i  (r_ent_q),
            .src_i  (AW_MAX'(id_rs_i[k*AW +: AW])),
            .used_i (id_rs_used_i[k]),
            .hit_o  (w_id_hit[k]),
            .s_o    (w_id_s[k]),
            .a_o    (w_id_a[k])
        );

        hazard_match #(
            .DEPTH (DEPTH),
            .LO    (2),
            .SELW  (SELW)
        ) u_ex_match (
            .ent_i  (r_ent_q),
            .src_i  (AW_MAX'(r_ex_rs_q[k*AW +: AW])),
            .used_i (r_ex_used_q[k]),
            .hit_o  (w_ex_hit[k]),
            .s_o    (w_ex_s[k]),
            .a_o    (w_ex_a[k])
        );
    end

    // A result sitting in the pipeline register in front of stage s is
    // forwardable once it was produced by stage s-1, i.e. a < s.
    // Non-branch consumers read in EX one cycle later, so they only stall
    // while a > s. Branches read in ID and stall while a >= s, except at the
    // last stage where the write-through register file serves the read.
    always_comb begin
        stall_o      = 1'b0;
        fwd_id_sel_o = {NSRC{SELW'(SEL_NONE)}};
        fwd_ex_sel_o = {NSRC{SELW'(SEL_NONE)}};
        for (int k = 0; k < int'(NSRC); k++) begin
            if (w_id_hit[k]) begin
                if (w_id_a[k] < SELW_MAX'(w_id_s[k])) begin
                    fwd_id_sel_o[k*SELW +: SELW] = w_id_s[k];
                end
                if (id_valid_i) begin
                    if (id_is_branch_i) begin
                        if ((w_id_a[k] >= SELW_MAX'(w_id_s[k])) &&
                            (SELW_MAX'(w_id_s[k]) < c_last)) begin
                            stall_o = 1'b1;
                        end
                    end else if (w_id_a[k] > SELW_MAX'(w_id_s[k])) begin
                        stall_o = 1'b1;
                    end
                end
            end
            if (w_ex_hit[k] && (w_ex_a[k] < SELW_MAX'(w_ex_s[k]))) begin
                fwd_ex_sel_o[k*SELW +: SELW] = w_ex_s[k];
            end
        end
    end

    always_comb begin
        pipe_empty_o = 1'b1;
        for (int s = 1; s <= int'(DEPTH); s++) begin
            if (r_ent_q[s].v) begin
                pipe_empty_o = 1'b0;
            end
        end
    end

    // Advance unless frozen. A stalled ID instruction becomes a bubble: no
    // writer enters stage 1 and EX sees no used sources. Invalid ID slots
    // also enter EX with no used sources.
    always_comb begin
        w_ent_d     = r_ent_q;
        w_ex_rs_d   = r_ex_rs_q;
        w_ex_used_d = r_ex_used_q;
        if (!hold_i) begin
            for (int s = int'(DEPTH); s >= 2; s--) begin
                w_ent_d[s] = r_ent_q[s-1];
            end
            w_ent_d[1].v  = id_valid_i & id_reg_write_i & ~stall_o;
            w_ent_d[1].rd = AW_MAX'(id_rd_i);
            w_ent_d[1].a  = id_is_load_i ? c_load_a : c_alu_a;
            if (stall_o) begin
                w_ex_used_d = '0;
            end else begin
                w_ex_rs_d   = id_rs_i;
                w_ex_used_d = id_rs_used_i & {NSRC{id_valid_i}};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 1; s <= int'(DEPTH); s++) begin
                r_ent_q[s] <= '0;
            end
            r_ex_rs_q   <= '0;
            r_ex_used_q <= '0;
        end else begin
            for (int s = 1; s <= int'(DEPTH); s++) begin
                r_ent_q[s] <= w_ent_d[s];
            end
            r_ex_rs_q   <= w_ex_rs_d;
            r_ex_used_q <= w_ex_used_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_fwd_unit
//  Description : Self-checking bench for hazard_fwd_unit. Directed table of
//                instruction sequences, hand-written hold/reset/deep-pipe
//                sequences, and randomized traffic against an in-flight
//                instruction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;

    localparam int AW    = 5;
    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int LOADS = 2;
    localparam int SELW  = 2;
    localparam int SELW4 = 3;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 id_valid_i = 1'b0;
    logic [NSRC*AW-1:0]   id_rs_i = '0;
    logic [NSRC-1:0]      id_rs_used_i = '0;
    logic [AW-1:0]        id_rd_i = '0;
    logic                 id_reg_write_i = 1'b0;
    logic                 id_is_load_i = 1'b0;
    logic                 id_is_branch_i = 1'b0;
    logic                 hold_i = 1'b0;

    logic                 stall_o;
    logic [NSRC*SELW-1:0] fwd_id_sel_o;
    logic [NSRC*SELW-1:0] fwd_ex_sel_o;
    logic                 pipe_empty_o;

    logic                  stall4;
    logic [NSRC*SELW4-1:0] id_sel4;
    logic [NSRC*SELW4-1:0] ex_sel4;
    logic                  empty4;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LOAD_STAGE(LOADS)) dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rs_used_i(id_rs_used_i), .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i),
        .id_is_load_i(id_is_load_i), .id_is_branch_i(id_is_branch_i), .hold_i(hold_i),
        .stall_o(stall_o), .fwd_id_sel_o(fwd_id_sel_o), .fwd_ex_sel_o(fwd_ex_sel_o),
        .pipe_empty_o(pipe_empty_o)
    );

    hazard_fwd_unit #(.AW(AW), .NSRC(NSRC), .DEPTH(4), .LOAD_STAGE(3)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rs_used_i(id_rs_used_i), .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i),
        .id_is_load_i(id_is_load_i), .id_is_branch_i(id_is_branch_i), .hold_i(hold_i),
        .stall_o(stall4), .fwd_id_sel_o(id_sel4), .fwd_ex_sel_o(ex_sel4),
        .pipe_empty_o(empty4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: in-flight instruction list -----------
    int m_v  [1:DEPTH];
    int m_rd [1:DEPTH];
    int m_a  [1:DEPTH];
    int m_ex_rs   [NSRC];
    int m_ex_used [NSRC];
    int m_stall;
    int m_empty;
    int m_id_sel [NSRC];
    int m_ex_sel [NSRC];

    // Youngest writer of rs at stage >= lo; returns its stage (0 = none).
    function automatic int nearest(input int rs, input int lo, output int a);
        a = 0;
        if (rs == 0) return 0;
        for (int s = lo; s <= DEPTH; s++) begin
            if (m_v[s] != 0 && m_rd[s] == rs) begin
                a = m_a[s];
                return s;
            end
        end
        return 0;
    endfunction

    task automatic model_eval(input bit audit);
        int s;
        int a;
        int rs;
        m_stall = 0;
        m_empty = 1;
        for (int d = 1; d <= DEPTH; d++) if (m_v[d] != 0) m_empty = 0;
        for (int k = 0; k < NSRC; k++) begin
            m_id_sel[k] = 0;
            m_ex_sel[k] = 0;
            rs = int'(id_rs_i[k*AW +: AW]);
            if (id_rs_used_i[k]) begin
                s = nearest(rs, 1, a);
                if (s != 0) begin
                    if (a <= s - 1) m_id_sel[k] = s;
                    if (id_valid_i) begin
                        if (id_is_branch_i) begin
                            if (a > s - 1 && s < DEPTH) m_stall = 1;
                        end else if (a > s) begin
                            m_stall = 1;
                        end
                    end
                end
            end
            if (m_ex_used[k] != 0) begin
                s = nearest(m_ex_rs[k], 2, a);
                if (s != 0) begin
                    if (a <= s - 1) m_ex_sel[k] = s;
                    if (audit) chk("ex_fwd_legal", (a <= s - 1) ? 1 : 0, 1);
                end
            end
        end
    endtask

    task automatic model_step();
        if (rst_i) begin
            for (int s = 1; s <= DEPTH; s++) begin
                m_v[s] = 0; m_rd[s] = 0; m_a[s] = 0;
            end
            for (int k = 0; k < NSRC; k++) begin
                m_ex_rs[k] = 0; m_ex_used[k] = 0;
            end
        end else if (!hold_i) begin
            for (int s = DEPTH; s >= 2; s--) begin
                m_v[s] = m_v[s-1]; m_rd[s] = m_rd[s-1]; m_a[s] = m_a[s-1];
            end
            m_v[1]  = (id_valid_i && id_reg_write_i && m_stall == 0) ? 1 : 0;
            m_rd[1] = int'(id_rd_i);
            m_a[1]  = id_is_load_i ? LOADS : 1;
            for (int k = 0; k < NSRC; k++) begin
                if (m_stall != 0) begin
                    m_ex_used[k] = 0;
                end else begin
                    m_ex_rs[k]   = int'(id_rs_i[k*AW +: AW]);
                    m_ex_used[k] = (id_valid_i && id_rs_used_i[k]) ? 1 : 0;
                end
            end
        end
    endtask

    // Advance one clock; inputs change only at posedge+1.
    task automatic tick();
        model_eval(1'b0);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input bit v, input int rs0, input int rs1, input int used,
                          input int rd, input bit rw, input bit ld, input bit br, input bit hold);
        id_valid_i     = v;
        id_rs_i        = {AW'(rs1), AW'(rs0)};
        id_rs_used_i   = NSRC'(used);
        id_rd_i        = AW'(rd);
        id_reg_write_i = rw;
        id_is_load_i   = ld;
        id_is_branch_i = br;
        hold_i         = hold;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic cmp_model();
        model_eval(1'b1);
        chk("rand_stall", int'(stall_o), m_stall);
        chk("rand_empty", int'(pipe_empty_o), m_empty);
        for (int k = 0; k < NSRC; k++) begin
            chk("rand_id_sel", int'(fwd_id_sel_o[k*SELW +: SELW]), m_id_sel[k]);
            chk("rand_ex_sel", int'(fwd_ex_sel_o[k*SELW +: SELW]), m_ex_sel[k]);
        end
    endtask

    // ---------------- directed table ---------------------------------------
    typedef struct {
        bit v; int rs0; int rs1; int used; int rd; bit rw; bit ld; bit br;
        int stall; int id_sel; int ex_sel; int empty;
    } vec_t;

    function automatic vec_t mk(input bit v, input int rs0, input int rs1, input int used,
                                input int rd, input bit rw, input bit ld, input bit br,
                                input int st, input int ids, input int exs, input int emp);
        vec_t t;
        t.v = v; t.rs0 = rs0; t.rs1 = rs1; t.used = used; t.rd = rd;
        t.rw = rw; t.ld = ld; t.br = br;
        t.stall = st; t.id_sel = ids; t.ex_sel = exs; t.empty = emp;
        return t;
    endfunction

    function automatic vec_t nop(input int exs, input int emp);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exs, emp);
    endfunction

    vec_t tbl [32];

    initial begin
        int cnt3, cnt4, sel3, sel4;
        bit done3, done4;

        // add r3 ; sub r9,r3,r1
        tbl[0]  = mk(1, 0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 1);
        tbl[1]  = mk(1, 3, 1, 3, 9, 1, 0, 0,   0, 0, 0, 0);
        tbl[2]  = nop(2, 0);
        tbl[3]  = nop(0, 0);
        tbl[4]  = nop(0, 0);
        tbl[5]  = nop(0, 1);
        // lw r4 ; add r10,r4,r5 (one stall, then EX forward from stage 3)
        tbl[6]  = mk(1, 2, 0, 1, 4, 1, 1, 0,   0, 0, 0, 1);
        tbl[7]  = mk(1, 4, 5, 3, 10, 1, 0, 0,  1, 0, 0, 0);
        tbl[8]  = mk(1, 4, 5, 3, 10, 1, 0, 0,  0, 0, 0, 0);
        tbl[9]  = nop(3, 0);
        tbl[10] = nop(0, 0);
        tbl[11] = nop(0, 0);
        // add r5 ; beq r5,r0
        tbl[12] = mk(1, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 1);
        tbl[13] = mk(1, 5, 0, 3, 0, 0, 0, 1,   1, 0, 0, 0);
        tbl[14] = mk(1, 5, 0, 3, 0, 0, 0, 1,   0, 2, 0, 0);
        tbl[15] = nop(3, 0);
        tbl[16] = nop(0, 1);
        // lw r6 ; beq r6,r7 (two stalls, then ID forward from stage 3)
        tbl[17] = mk(1, 0, 0, 0, 6, 1, 1, 0,   0, 0, 0, 1);
        tbl[18] = mk(1, 6, 7, 3, 0, 0, 0, 1,   1, 0, 0, 0);
        tbl[19] = mk(1, 6, 7, 3, 0, 0, 0, 1,   1, 0, 0, 0);
        tbl[20] = mk(1, 6, 7, 3, 0, 0, 0, 1,   0, 3, 0, 0);
        tbl[21] = nop(0, 1);
        // r0 never forwards; nearest of two r8 producers wins
        tbl[22] = mk(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1);
        tbl[23] = mk(1, 0, 0, 3, 11, 1, 0, 0,  0, 0, 0, 0);
        tbl[24] = nop(0, 0);
        tbl[25] = mk(1, 0, 0, 0, 8, 1, 0, 0,   0, 0, 0, 0);
        tbl[26] = mk(1, 0, 0, 0, 8, 1, 0, 0,   0, 0, 0, 0);
        tbl[27] = mk(1, 8, 0, 1, 12, 1, 0, 0,  0, 0, 0, 0);
        tbl[28] = nop(2, 0);
        tbl[29] = nop(0, 0);
        tbl[30] = nop(0, 0);
        tbl[31] = nop(0, 1);

        for (int s = 1; s <= DEPTH; s++) begin m_v[s] = 0; m_rd[s] = 0; m_a[s] = 0; end
        for (int k = 0; k < NSRC; k++) begin m_ex_rs[k] = 0; m_ex_used[k] = 0; end

        // Reset state
        do_reset();
        #1;
        chk("reset_stall", int'(stall_o), 0);
        chk("reset_id_sel", int'(fwd_id_sel_o), 0);
        chk("reset_ex_sel", int'(fwd_ex_sel_o), 0);
        chk("reset_empty", int'(pipe_empty_o), 1);
        chk("reset_empty_d4", int'(empty4), 1);

        // Directed table (only source 0 ever has a producer in flight)
        for (int i = 0; i < 32; i++) begin
            set_in(tbl[i].v, tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].rd,
                   tbl[i].rw, tbl[i].ld, tbl[i].br, 0);
            #1;
            chk($sformatf("tbl%0d_stall", i), int'(stall_o), tbl[i].stall);
            chk($sformatf("tbl%0d_id_sel", i), int'(fwd_id_sel_o), tbl[i].id_sel);
            chk($sformatf("tbl%0d_ex_sel", i), int'(fwd_ex_sel_o), tbl[i].ex_sel);
            chk($sformatf("tbl%0d_empty", i), int'(pipe_empty_o), tbl[i].empty);
            tick();
        end

        // Freeze during a load-use stall
        do_reset();
        set_in(1, 2, 0, 1, 4, 1, 1, 0, 0);
        tick();
        set_in(1, 4, 5, 3, 10, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", int'(stall_o), 1);
            chk("hold_id_sel", int'(fwd_id_sel_o), 0);
            chk("hold_empty", int'(pipe_empty_o), 0);
            tick();
        end
        hold_i = 1'b0;
        #1;
        chk("release_stall", int'(stall_o), 1);
        tick();
        #1;
        chk("after_release_stall", int'(stall_o), 0);
        tick();
        #1;
        chk("after_release_ex_sel", int'(fwd_ex_sel_o), 3);

        // Reset with a load in flight
        do_reset();
        set_in(1, 0, 0, 0, 6, 1, 1, 0, 0);
        tick();
        set_in(1, 6, 0, 1, 9, 1, 0, 0, 0);
        #1;
        chk("pre_rst_stall", int'(stall_o), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("post_rst_stall", int'(stall_o), 0);
        chk("post_rst_empty", int'(pipe_empty_o), 1);
        chk("post_rst_id_sel", int'(fwd_id_sel_o), 0);

        // Branch behind a load: stall length on default and deeper pipes
        do_reset();
        set_in(1, 0, 0, 0, 6, 1, 1, 0, 0);
        tick();
        set_in(1, 6, 7, 3, 0, 0, 0, 1, 0);
        cnt3 = 0; cnt4 = 0; sel3 = -1; sel4 = -1; done3 = 0; done4 = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (!done3) begin
                if (stall_o) cnt3++;
                else begin done3 = 1; sel3 = int'(fwd_id_sel_o[SELW-1:0]); end
            end
            if (!done4) begin
                if (stall4) cnt4++;
                else begin done4 = 1; sel4 = int'(id_sel4[SELW4-1:0]); end
            end
            if (done3 && done4) break;
            tick();
        end
        chk("br_load_done", int'(done3 & done4), 1);
        chk("br_load_stalls_d3", cnt3, 2);
        chk("br_load_sel_d3", sel3, 3);
        chk("br_load_stalls_d4", cnt4, 3);
        chk("br_load_sel_d4", sel4, 4);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
                   $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0);
            rst_i = ($urandom_range(0, 99) == 0);
            #1;
            cmp_model();
            tick();
        end
        rst_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
